// File: rtl/led_counter_param.sv
// led_counter_param
//   Prescaled up/down counter with a configurable terminal count, a debounced
//   single-step button, a one-shot mode and an LED window onto the count.
//
// Parameters
//   WIDTH     counter width (8..32)
//   DIV_W     prescaler reload width
//   OUT_W     LED window width (1..WIDTH)
//   LED_MSB   MSB of the LED window within cnt
//   DB_CYCLES stable cycles required before the debounced level changes (>=1)
//
// Ports
//   clk      in   clock, rising edge
//   rst_n    in   synchronous active-low reset
//   en       in   count enable (level)
//   up_dn    in   1 = count up, 0 = count down
//   mode     in   00 free-run, 01 single-step, 10 one-shot, 11 hold
//   step_btn in   raw asynchronous push button
//   div      in   prescaler reload; tick every div+1 running cycles
//   limit    in   terminal count; counter range is 0..limit
//   cnt      out  registered count
//   led_out  out  cnt[LED_MSB -: OUT_W]
//   wrap     out  one-cycle pulse after an advance that wrapped
//   done     out  one-shot completed (level)
module led_counter_param #(
  parameter int WIDTH     = 32,
  parameter int DIV_W     = 16,
  parameter int OUT_W     = 10,
  parameter int LED_MSB   = 25,
  parameter int DB_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic [1:0]       mode,
  input  logic             step_btn,
  input  logic [DIV_W-1:0] div,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] cnt,
  output logic [OUT_W-1:0] led_out,
  output logic             wrap,
  output logic             done
);

  localparam logic [1:0] MODE_FREE    = 2'b00;
  localparam logic [1:0] MODE_STEP    = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;

  // Debounce counter only needs to reach DB_CYCLES-1; the +1 keeps it >= 1 bit.
  localparam int DB_W = $clog2(DB_CYCLES + 1);

  // ---------------------------------------------------------------------------
  // Prescaler: runs only in the tick-driven modes, holds otherwise.
  // The reload value is sampled only when the counter reaches zero, so a
  // new div takes effect at the next reload.
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] pre_cnt;
  logic             run;
  logic             tick;

  assign run  = en && (mode == MODE_FREE || mode == MODE_ONESHOT);
  assign tick = run && (pre_cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_cnt <= div;
    end else if (run) begin
      if (pre_cnt == '0) pre_cnt <= div;
      else               pre_cnt <= pre_cnt - DIV_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Button path: 2-FF synchroniser, then a stable-count debouncer. The level
  // flips only after the synchronised input has disagreed with it for
  // DB_CYCLES consecutive cycles; any agreement restarts the count.
  // ---------------------------------------------------------------------------
  logic            sync1;
  logic            sync2;
  logic            db_level;
  logic            db_prev;
  logic [DB_W-1:0] db_cnt;
  logic            step;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      db_level <= 1'b0;
      db_prev  <= 1'b0;
      db_cnt   <= '0;
    end else begin
      sync1   <= step_btn;
      sync2   <= sync1;
      db_prev <= db_level;
      if (sync2 != db_level) begin
        if (db_cnt == DB_W'(DB_CYCLES - 1)) begin
          db_level <= sync2;
          db_cnt   <= '0;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // Rising edge of the debounced level.
  assign step = db_level && !db_prev;

  // ---------------------------------------------------------------------------
  // Advance decision and next-count arithmetic. tick already implies en and a
  // tick-driven mode; the step path is only honoured in single-step mode.
  // ---------------------------------------------------------------------------
  logic             adv;
  logic [WIDTH-1:0] cnt_next;
  logic             wrap_cond;

  assign adv = en && ((tick && !done) || (mode == MODE_STEP && step));

  always_comb begin
    cnt_next  = cnt;
    wrap_cond = 1'b0;
    if (up_dn) begin
      if (cnt >= limit) begin
        cnt_next  = '0;
        wrap_cond = 1'b1;
      end else begin
        cnt_next = cnt + WIDTH'(1);
      end
    end else begin
      if (cnt == '0) begin
        cnt_next  = limit;
        wrap_cond = 1'b1;
      end else if (cnt > limit) begin
        // Re-entering the range after limit was lowered is not a wrap.
        cnt_next = limit;
      end else begin
        cnt_next = cnt - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt  <= '0;
      wrap <= 1'b0;
      done <= 1'b0;
    end else begin
      wrap <= adv && wrap_cond;
      if (adv) cnt <= cnt_next;
      // done tracks a one-shot run; leaving one-shot or dropping en clears it
      // without touching cnt.
      if (!en || mode != MODE_ONESHOT) done <= 1'b0;
      else if (adv && wrap_cond)       done <= 1'b1;
    end
  end

  assign led_out = cnt[LED_MSB -: OUT_W];

endmodule
